// File: rtl/sdram_responder_pkg.sv
// Shared SDRAM definitions: command encodings ({cs_n,ras_n,cas_n,we_n}),
// sticky error bit indices, and the command decoder used by the responder.
package sdram_responder_pkg;

  typedef enum logic [3:0] {
    CMD_LOAD_MODE  = 4'b0000,
    CMD_REFRESH    = 4'b0001,
    CMD_PRECHARGE  = 4'b0010,
    CMD_ACTIVE     = 4'b0011,
    CMD_WRITE      = 4'b0100,
    CMD_READ       = 4'b0101,
    CMD_BURST_TERM = 4'b0110,
    CMD_NOP        = 4'b0111
  } sdram_cmd_e;

  localparam int ERR_ACT_OPEN   = 0; // ACTIVE to an open bank
  localparam int ERR_RW_CLOSED  = 1; // READ/WRITE to a closed bank
  localparam int ERR_RCD        = 2; // READ/WRITE inside tRCD
  localparam int ERR_RP         = 3; // ACTIVE inside tRP
  localparam int ERR_RFC        = 4; // any command inside tRFC
  localparam int ERR_REF_OPEN   = 5; // REFRESH with a bank open
  localparam int ERR_MODE_DQ    = 6; // bad LOAD_MODE or WRITE without DQ drive
  localparam int ERR_NO_MODE    = 7; // command before mode register loaded

  // Deselect collapses to NOP so the rest of the decoder sees one encoding.
  function automatic sdram_cmd_e decode_cmd(input logic cs_n, input logic ras_n,
                                            input logic cas_n, input logic we_n);
    return cs_n ? CMD_NOP : sdram_cmd_e'({1'b0, ras_n, cas_n, we_n});
  endfunction

endpackage

// File: rtl/sdram_responder_if.sv
// SDRAM command/data bus between controller (master) and device (slave).
//   cs_n/ras_n/cas_n/we_n/cke : command and clock enable
//   addr/ba                   : row, column or mode value; bank
//   dq_write/dqm/dq_en        : write data, byte mask (1 = masked), drive flag
//   dq_read/dq_read_valid     : registered read data and its strobe
interface sdram_responder_if #(
  parameter int SDRAM_DATA = 16,
  parameter int SDRAM_BA   = 2,
  parameter int SDRAM_ROW  = 13
);
  logic                    sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic                    sdram_cke;
  logic [SDRAM_ROW-1:0]    sdram_addr;
  logic [SDRAM_BA-1:0]     sdram_ba;
  logic [SDRAM_DATA-1:0]   sdram_dq_write;
  logic [SDRAM_DATA/8-1:0] sdram_dqm;
  logic                    sdram_dq_en;
  logic [SDRAM_DATA-1:0]   sdram_dq_read;
  logic                    sdram_dq_read_valid;

  modport master (
    output sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_cke,
           sdram_addr, sdram_ba, sdram_dq_write, sdram_dqm, sdram_dq_en,
    input  sdram_dq_read, sdram_dq_read_valid
  );

  modport slave (
    input  sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_cke,
           sdram_addr, sdram_ba, sdram_dq_write, sdram_dqm, sdram_dq_en,
    output sdram_dq_read, sdram_dq_read_valid
  );
endinterface

// File: rtl/sdram_responder_mem.sv
// Backing store: single-port synchronous RAM, 2**AW x DW, per-byte write
// enable, registered read data one cycle after re_i.
//   clk     : clock
//   addr_i  : word index
//   re_i    : read strobe (rdata_o updates next cycle)
//   we_i    : per-byte write enables
//   wdata_i : write data
//   rdata_o : read data
module sdram_responder_mem #(
  parameter int DW = 16,
  parameter int AW = 12
) (
  input  logic            clk,
  input  logic [AW-1:0]   addr_i,
  input  logic            re_i,
  input  logic [DW/8-1:0] we_i,
  input  logic [DW-1:0]   wdata_i,
  output logic [DW-1:0]   rdata_o
);
  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < DW/8; b++)
      if (we_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/sdram_responder.sv
// SDRAM device-side responder. Decodes controller commands, tracks per-bank
// open rows and tRCD/tRP windows plus the global tRFC window, stores writes
// with DQM masking and returns reads after CAS latency 2 or 3. Protocol
// violations set sticky err bits and the offending command is dropped.
//   clk, reset  : clock, synchronous active-high reset
//   bus         : SDRAM command/data bus (slave side)
//   bank_open   : per-bank active flag
//   mode_loaded : a LOAD_MODE has been accepted
//   err         : sticky violation flags
module sdram_responder
  import sdram_responder_pkg::*;
#(
  parameter int SDRAM_DATA  = 16,
  parameter int SDRAM_BA    = 2,
  parameter int SDRAM_ROW   = 13,
  parameter int SDRAM_COL   = 9,
  parameter int MEM_AW      = 12,
  parameter int tRCD_CYCLE  = 2,
  parameter int tRP_CYCLE   = 2,
  parameter int tRFC_CYCLE  = 6,
  localparam int SDRAM_BANK = 2**SDRAM_BA
) (
  input  logic                  clk,
  input  logic                  reset,
  sdram_responder_if.slave      bus,
  output logic [SDRAM_BANK-1:0] bank_open,
  output logic                  mode_loaded,
  output logic [7:0]            err
);
  localparam int NB = SDRAM_DATA/8;
  localparam int TW = $clog2(tRCD_CYCLE + tRP_CYCLE + tRFC_CYCLE + 1);
  localparam int IW = SDRAM_BA + SDRAM_ROW + SDRAM_COL;
  typedef logic [TW-1:0] tmr_t;
  localparam tmr_t RCD_LD = tmr_t'(tRCD_CYCLE - 1);
  localparam tmr_t RP_LD  = tmr_t'(tRP_CYCLE - 1);
  localparam tmr_t RFC_LD = tmr_t'(tRFC_CYCLE - 1);

  logic [SDRAM_BANK-1:0]                open_q, open_d;
  logic [SDRAM_BANK-1:0][SDRAM_ROW-1:0] row_q, row_d;
  tmr_t [SDRAM_BANK-1:0]                rcd_q, rcd_d, rp_q, rp_d;
  tmr_t                                 rfc_q, rfc_d;
  logic                                 mode_q, mode_d, cl3_q, cl3_d;
  logic [7:0]                           err_q, err_d, err_now;

  sdram_cmd_e          cmd;
  logic [SDRAM_BA-1:0] ba;
  logic                accept, rd_go, wr_go, mode_ok;

  // cke low: command ignored, timers hold.
  assign cmd = bus.sdram_cke ? decode_cmd(bus.sdram_cs_n, bus.sdram_ras_n,
                                          bus.sdram_cas_n, bus.sdram_we_n)
                             : CMD_NOP;
  assign ba  = bus.sdram_ba;

  // Read pipeline: vld_pipe_q[0] = RAM output valid, [1] = extra CL3 stage.
  logic [1:0]            vld_pipe_q;
  logic [SDRAM_DATA-1:0] rdata, dat1_q, dq_read_q;
  logic                  dq_vld_q;

  // CL may only change with every bank closed and nothing in flight, so the
  // delay-line tap never switches under a pending read.
  assign mode_ok = (bus.sdram_addr[6:4] == 3'd2 || bus.sdram_addr[6:4] == 3'd3) &&
                   bus.sdram_addr[2:0] == 3'd0 && open_q == '0 && vld_pipe_q == '0;

  always_comb begin
    err_now = '0;
    if (cmd != CMD_NOP && cmd != CMD_BURST_TERM && rfc_q != '0) err_now[ERR_RFC] = 1'b1;
    case (cmd)
      CMD_ACTIVE: begin
        if (open_q[ba])       err_now[ERR_ACT_OPEN] = 1'b1;
        if (rp_q[ba] != '0)   err_now[ERR_RP]       = 1'b1;
        if (!mode_q)          err_now[ERR_NO_MODE]  = 1'b1;
      end
      CMD_READ, CMD_WRITE: begin
        if (!open_q[ba])      err_now[ERR_RW_CLOSED] = 1'b1;
        if (rcd_q[ba] != '0)  err_now[ERR_RCD]       = 1'b1;
        if (!mode_q)          err_now[ERR_NO_MODE]   = 1'b1;
        if (cmd == CMD_WRITE && !bus.sdram_dq_en) err_now[ERR_MODE_DQ] = 1'b1;
      end
      CMD_REFRESH: begin
        if (open_q != '0)     err_now[ERR_REF_OPEN] = 1'b1;
        if (!mode_q)          err_now[ERR_NO_MODE]  = 1'b1;
      end
      CMD_LOAD_MODE: if (!mode_ok) err_now[ERR_MODE_DQ] = 1'b1;
      default: ;
    endcase
  end

  assign accept = (err_now == '0);
  assign rd_go  = accept && cmd == CMD_READ;
  assign wr_go  = accept && cmd == CMD_WRITE;

  always_comb begin
    open_d = open_q;
    row_d  = row_q;
    rcd_d  = rcd_q;
    rp_d   = rp_q;
    rfc_d  = rfc_q;
    mode_d = mode_q;
    cl3_d  = cl3_q;
    err_d  = err_q | err_now;
    if (bus.sdram_cke) begin
      for (int b = 0; b < SDRAM_BANK; b++) begin
        if (rcd_q[b] != '0) rcd_d[b] = rcd_q[b] - 1'b1;
        if (rp_q[b]  != '0) rp_d[b]  = rp_q[b]  - 1'b1;
      end
      if (rfc_q != '0) rfc_d = rfc_q - 1'b1;
      if (accept) begin
        case (cmd)
          CMD_ACTIVE: begin
            open_d[ba] = 1'b1;
            row_d[ba]  = bus.sdram_addr;
            rcd_d[ba]  = RCD_LD;
          end
          CMD_PRECHARGE:
            for (int b = 0; b < SDRAM_BANK; b++)
              if (bus.sdram_addr[10] || ba == SDRAM_BA'(b)) begin
                open_d[b] = 1'b0;
                rp_d[b]   = RP_LD;
              end
          CMD_REFRESH:   rfc_d = RFC_LD;
          CMD_LOAD_MODE: begin
            mode_d = 1'b1;
            cl3_d  = (bus.sdram_addr[6:4] == 3'd3);
          end
          default: ;
        endcase
      end
    end
  end

  // Word index: low MEM_AW bits of {bank, open row, column}.
  logic [IW-1:0] idx_full;
  logic [NB-1:0] mem_we;
  logic          unused_idx;
  assign idx_full   = {ba, row_q[ba], bus.sdram_addr[SDRAM_COL-1:0]};
  assign unused_idx = ^idx_full[IW-1:MEM_AW];
  assign mem_we     = wr_go ? ~bus.sdram_dqm : '0;

  sdram_responder_mem #(.DW(SDRAM_DATA), .AW(MEM_AW)) u_mem (
    .clk     (clk),
    .addr_i  (idx_full[MEM_AW-1:0]),
    .re_i    (rd_go),
    .we_i    (mem_we),
    .wdata_i (bus.sdram_dq_write),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      open_q     <= '0;
      row_q      <= '0;
      rcd_q      <= '0;
      rp_q       <= '0;
      rfc_q      <= '0;
      mode_q     <= 1'b0;
      cl3_q      <= 1'b0;
      err_q      <= '0;
      vld_pipe_q <= '0;
      dat1_q     <= '0;
      dq_vld_q   <= 1'b0;
      dq_read_q  <= '0;
    end else begin
      open_q     <= open_d;
      row_q      <= row_d;
      rcd_q      <= rcd_d;
      rp_q       <= rp_d;
      rfc_q      <= rfc_d;
      mode_q     <= mode_d;
      cl3_q      <= cl3_d;
      err_q      <= err_d;
      vld_pipe_q <= {vld_pipe_q[0], rd_go};
      if (vld_pipe_q[0]) dat1_q <= rdata;
      dq_vld_q   <= cl3_q ? vld_pipe_q[1] : vld_pipe_q[0];
      if (cl3_q ? vld_pipe_q[1] : vld_pipe_q[0])
        dq_read_q <= cl3_q ? dat1_q : rdata;
    end
  end

  assign bus.sdram_dq_read       = dq_read_q;
  assign bus.sdram_dq_read_valid = dq_vld_q;
  assign bank_open               = open_q;
  assign mode_loaded             = mode_q;
  assign err                     = err_q;
endmodule
